// File: rtl/gate_sweep_checker_pkg.sv
// rtl/gate_sweep_checker_pkg.sv - shared state encoding and sweep-size helper
package gate_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nvec(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_sweep_counter.sv
// rtl/gate_sweep_checker_sweep_counter.sv - hold counter and vector counter for the sweep
module sweep_counter #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run,
  output logic [WIDTH-1:0] stim,
  output logic             sample_stb,
  output logic             last
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);

  logic [HW-1:0] hold_cnt;

  assign sample_stb = run && (hold_cnt == HOLD_MAX);
  assign last       = (stim == {WIDTH{1'b1}});

  // The final vector is held after its sample so the report shows where the sweep ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim     <= '0;
      hold_cnt <= '0;
    end else if (clear) begin
      stim     <= '0;
      hold_cnt <= '0;
    end else if (run) begin
      if (sample_stb) begin
        hold_cnt <= '0;
        if (!last) stim <= stim + WIDTH'(1);
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - sweeps all input vectors of a gate and checks it against a truth table
module gate_sweep_checker
  import gate_sweep_checker_pkg::*;
#(
  parameter int                     WIDTH = 2,
  parameter int                     HOLD  = 5,
  parameter logic [nvec(WIDTH)-1:0] TRUTH = 4'b1000,
  parameter int                     ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] first_err_vec,
  output logic             first_err_vld,
  output logic             sample_stb
);

  state_t state;
  logic   accept;
  logic   last;
  logic   mismatch;

  assign accept = start && (state != ST_RUN);

  // Case inequality so an X or Z from the gate is reported rather than silently matching.
  always_comb begin
    mismatch = 1'b0;
    if (sample_stb) mismatch = (dut_out !== TRUTH[stim]);
  end

  sweep_counter #(
    .WIDTH(WIDTH),
    .HOLD (HOLD)
  ) u_sweep_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (accept),
    .run       (state == ST_RUN),
    .stim      (stim),
    .sample_stb(sample_stb),
    .last      (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_RUN;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_vec <= '0;
            first_err_vld <= 1'b0;
          end
        end
        ST_RUN: begin
          if (sample_stb) begin
            if (mismatch) begin
              if (err_count != {ERRW{1'b1}}) err_count <= err_count + ERRW'(1);
              if (!first_err_vld) begin
                first_err_vec <= stim;
                first_err_vld <= 1'b1;
              end
            end
            if (last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !first_err_vld && !mismatch;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
